// File: rtl/count32_driver_pkg.sv
// Shared constants for the count32 driver: modo encodings, FSM state codes, step sizes.
package count_pkg;
  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DN   = 2'b01;
  localparam logic [1:0] MODO_DN3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_LCHK  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int DN3_STEP = 3;
endpackage

// File: rtl/count32_driver_if.sv
// Host command/status bus plus the counter-side signals of the count32 driver.
interface count32_driver_if #(parameter int WIDTH = 32, parameter int STEP_W = 16);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [WIDTH-1:0]  cmd_load;
  logic [STEP_W-1:0] cmd_steps;
  logic              cnt_enable;
  logic [1:0]        cnt_modo;
  logic [WIDTH-1:0]  cnt_D;
  logic [WIDTH-1:0]  cnt_Q;
  logic              cnt_rco;
  logic              done;
  logic [WIDTH-1:0]  final_q;
  logic [STEP_W-1:0] rco_count;
  logic [STEP_W-1:0] err_count;
  logic              error;

  modport master (
    output cmd_valid, cmd_mode, cmd_load, cmd_steps, cnt_Q, cnt_rco,
    input  cmd_ready, cnt_enable, cnt_modo, cnt_D, done, final_q, rco_count, err_count, error
  );
  modport slave (
    input  cmd_valid, cmd_mode, cmd_load, cmd_steps, cnt_Q, cnt_rco,
    output cmd_ready, cnt_enable, cnt_modo, cnt_D, done, final_q, rco_count, err_count, error
  );
endinterface

// File: rtl/count32_driver_model.sv
// Reference model of the counter value: load, then modular up/down/down-by-3 steps.
module count32_model
  import count_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  output logic [WIDTH-1:0] exp
);
  always_ff @(posedge clk) begin
    if (reset) begin
      exp <= '0;
    end else if (load_en) begin
      exp <= load_val;
    end else if (step_en) begin
      case (mode)
        MODO_UP:  exp <= exp + WIDTH'(1);
        MODO_DN:  exp <= exp - WIDTH'(1);
        MODO_DN3: exp <= exp - WIDTH'(DN3_STEP);
        default:  exp <= exp;
      endcase
    end
  end
endmodule

// File: rtl/count32_driver.sv
// Command-driven stimulus/checker for the count32 counter: load, step, compare, report.
module count32_driver
  import count_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  count32_driver_if.slave bus
);
  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  load_q;
  logic [WIDTH-1:0]  exp;
  logic [WIDTH-1:0]  final_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] remaining;
  logic [STEP_W-1:0] rco_cnt;
  logic [STEP_W-1:0] err_cnt;
  logic              rco_d;
  logic              run_first;
  logic              cmp_en;
  logic              mism;
  logic              rco_rise;

  count32_model #(.WIDTH(WIDTH)) u_model (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode_q),
    .load_en  (state == ST_LOAD),
    .load_val (load_q),
    .step_en  (state == ST_RUN),
    .exp      (exp)
  );

  // The first RUN cycle still shows the loaded value, already checked in LCHK.
  always_comb begin
    cmp_en   = (state == ST_LCHK) || (state == ST_RUN && !run_first) || (state == ST_DRAIN);
    mism     = cmp_en && (bus.cnt_Q != exp);
    rco_rise = bus.cnt_rco && !rco_d && (state == ST_RUN || state == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODO_UP;
      load_q    <= '0;
      steps_q   <= '0;
      remaining <= '0;
      run_first <= 1'b0;
      final_q   <= '0;
      rco_cnt   <= '0;
      err_cnt   <= '0;
      rco_d     <= 1'b0;
    end else begin
      rco_d <= bus.cnt_rco;
      if (mism && err_cnt != {STEP_W{1'b1}})     err_cnt <= err_cnt + STEP_W'(1);
      if (rco_rise && rco_cnt != {STEP_W{1'b1}}) rco_cnt <= rco_cnt + STEP_W'(1);
      case (state)
        ST_IDLE: if (bus.cmd_valid) begin
          mode_q  <= bus.cmd_mode;
          load_q  <= bus.cmd_load;
          steps_q <= bus.cmd_steps;
          rco_cnt <= '0;
          err_cnt <= '0;
          state   <= ST_LOAD;
        end
        ST_LOAD: state <= ST_LCHK;
        ST_LCHK: begin
          remaining <= steps_q;
          run_first <= 1'b1;
          state     <= (mode_q == MODO_LOAD || steps_q == '0) ? ST_DRAIN : ST_RUN;
        end
        ST_RUN: begin
          run_first <= 1'b0;
          remaining <= remaining - STEP_W'(1);
          if (remaining == STEP_W'(1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          final_q <= bus.cnt_Q;
          state   <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready  = (state == ST_IDLE);
    bus.cnt_enable = (state == ST_LOAD) || (state == ST_RUN);
    bus.cnt_modo   = (state == ST_LOAD) ? MODO_LOAD : (state == ST_RUN) ? mode_q : MODO_UP;
    bus.cnt_D      = load_q;
    bus.done       = (state == ST_DONE);
    bus.final_q    = final_q;
    bus.rco_count  = rco_cnt;
    bus.err_count  = err_cnt;
    bus.error      = (err_cnt != '0);
  end
endmodule

// File: tb/tb_count32_driver.sv
// Bench for count32_driver: behavioural count32 with optional stuck bit, scoreboard on done.
module tb_count32_driver;
  localparam int W  = 32;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fault = 1'b0;
  logic [W-1:0] q;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  count32_driver_if #(.WIDTH(W), .STEP_W(SW)) bus ();
  count32_driver #(.WIDTH(W), .STEP_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural counter: Q registered, rco high while Q is all ones.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (bus.cnt_enable) begin
      case (bus.cnt_modo)
        2'b00:   q <= q + 32'd1;
        2'b01:   q <= q - 32'd1;
        2'b10:   q <= q - 32'd3;
        default: q <= bus.cnt_D;
      endcase
    end
  end
  assign bus.cnt_Q   = fault ? (q & ~32'h10) : q;
  assign bus.cnt_rco = &q;

  typedef struct {
    logic [W-1:0]  fq;
    logic [SW-1:0] rc;
    logic [SW-1:0] ec;
    logic          er;
    int            lat;
    int            acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("final_q", 64'(bus.final_q), 64'(e.fq));
        chk("rco_count", 64'(bus.rco_count), 64'(e.rc));
        chk("err_count", 64'(bus.err_count), 64'(e.ec));
        chk("error", 64'(bus.error), 64'(e.er));
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] mode, input logic [W-1:0] load, input logic [SW-1:0] steps,
                       input bit push, input logic [W-1:0] fq, input logic [SW-1:0] rc,
                       input logic [SW-1:0] ec, input logic er);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) chk("ready_timeout", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_mode  = mode;
    bus.cmd_load  = load;
    bus.cmd_steps = steps;
    bus.cmd_valid = 1'b1;
    if (push) begin
      e.fq = fq; e.rc = rc; e.ec = ec; e.er = er;
      e.lat = (mode == 2'b11 || steps == 0) ? 4 : int'(steps) + 4;
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 2'b00;
    bus.cmd_load  = '0;
    bus.cmd_steps = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_enable", 64'(bus.cnt_enable), 64'd0);
    chk("rst_modo", 64'(bus.cnt_modo), 64'd0);
    chk("rst_D", 64'(bus.cnt_D), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_final_q", 64'(bus.final_q), 64'd0);
    chk("rst_rco_count", 64'(bus.rco_count), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    reset = 1'b0;

    issue(2'b00, 32'h0000_000E, 16'd3, 1'b1, 32'h0000_0011, 16'd0, 16'd0, 1'b0);
    wait_drain();
    issue(2'b00, 32'hFFFF_FFFE, 16'd3, 1'b1, 32'h0000_0001, 16'd1, 16'd0, 1'b0);
    wait_drain();
    issue(2'b10, 32'h0000_0004, 16'd2, 1'b1, 32'hFFFF_FFFE, 16'd0, 16'd0, 1'b0);
    wait_drain();
    // Down by one through zero: rco rises as Q reaches FFFFFFFF in the DRAIN cycle.
    issue(2'b01, 32'h0000_0001, 16'd2, 1'b1, 32'hFFFF_FFFF, 16'd1, 16'd0, 1'b0);
    wait_drain();

    // Bit 4 stuck low: compares of 10, 11 (RUN) and 12 (DRAIN) mismatch.
    fault = 1'b1;
    issue(2'b00, 32'h0000_000C, 16'd6, 1'b1, 32'h0000_0002, 16'd0, 16'd3, 1'b1);
    wait_drain();
    fault = 1'b0;
    @(negedge clk);
    chk("error_held", 64'(bus.error), 64'd1);
    chk("err_held", 64'(bus.err_count), 64'd3);

    issue(2'b11, 32'hA5A5_A5A5, 16'd5, 1'b1, 32'hA5A5_A5A5, 16'd0, 16'd0, 1'b0);
    chk("ld_enable", 64'(bus.cnt_enable), 64'd1);
    chk("ld_modo", 64'(bus.cnt_modo), 64'd3);
    chk("ld_D", 64'(bus.cnt_D), 64'hA5A5_A5A5);
    chk("error_cleared", 64'(bus.error), 64'd0);
    @(posedge clk);
    #1 chk("lchk_enable", 64'(bus.cnt_enable), 64'd0);
    wait_drain();
    issue(2'b00, 32'hA5A5_A5A5, 16'd0, 1'b1, 32'hA5A5_A5A5, 16'd0, 16'd0, 1'b0);
    wait_drain();
    // rco rises in LCHK (not counted) and stays high through the first RUN cycle.
    issue(2'b00, 32'hFFFF_FFFF, 16'd1, 1'b1, 32'h0000_0000, 16'd0, 16'd0, 1'b0);
    wait_drain();

    issue(2'b00, 32'h0000_0000, 16'd10, 1'b0, '0, '0, '0, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("run3_enable", 64'(bus.cnt_enable), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_enable", 64'(bus.cnt_enable), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_final_q", 64'(bus.final_q), 64'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);

    issue(2'b00, 32'h7FFF_FFFE, 16'd2, 1'b1, 32'h8000_0000, 16'd0, 16'd0, 1'b0);
    wait_drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
